// File: rtl/gal8_inv_seq_pkg.sv
// Shared constants for the GF(2^8) sequential inverter.
package gal8_inv_seq_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned STEP_W = 3;
  localparam int unsigned STATE_W = 2;

  // FSM state encoding
  localparam logic [STATE_W-1:0] ST_IDLE = 2'd0;
  localparam logic [STATE_W-1:0] ST_RUN  = 2'd1;
  localparam logic [STATE_W-1:0] ST_DONE = 2'd2;

  // Exponent 254: a^254 == a^-1 in GF(2^8), and maps 0 to 0
  localparam logic [DATA_W-1:0] INV_EXP = 8'hFE;

  // Field polynomial x^8+x^4+x^3+x+1
  localparam logic [DATA_W:0] FIELD_POLY = 9'h11B;

endpackage

// File: rtl/gal8_mul.sv
// Combinational GF(2^8) multiplier modulo the field polynomial.
module gal8_mul
  import gal8_inv_seq_pkg::*;
(
  input  logic [DATA_W-1:0] a_i,
  input  logic [DATA_W-1:0] b_i,
  output logic [DATA_W-1:0] prod_c_o
);

  logic [DATA_W-1:0] prod_c;
  logic [DATA_W-1:0] shift_c;

  // Shift-and-add: accumulate a*x^i for each set bit of b, reducing on every shift
  always_comb begin
    prod_c  = '0;
    shift_c = a_i;
    for (int i = 0; i < int'(DATA_W); i++) begin
      if (b_i[i]) begin
        prod_c = prod_c ^ shift_c;
      end
      shift_c = {shift_c[DATA_W-2:0], 1'b0} ^
                (shift_c[DATA_W-1] ? FIELD_POLY[DATA_W-1:0] : DATA_W'(0));
    end
  end

  assign prod_c_o = prod_c;

endmodule

// File: rtl/gal8_inv_seq.sv
// Sequential GF(2^8) inverter: square-and-multiply for a^254, one exponent bit per cycle.
module gal8_inv_seq
  import gal8_inv_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
);

  logic [STATE_W-1:0] state_q, state_d;
  logic [DATA_W-1:0]  base_q, base_d;
  logic [DATA_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;

  logic [DATA_W-1:0]  sq_c;
  logic [DATA_W-1:0]  mul_c;

  // base^2 for the next exponent bit
  gal8_mul u_sq (
    .a_i      (base_q),
    .b_i      (base_q),
    .prod_c_o (sq_c)
  );

  // acc*base, taken when the current exponent bit is set
  gal8_mul u_mul (
    .a_i      (acc_q),
    .b_i      (base_q),
    .prod_c_o (mul_c)
  );

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      base_q      <= 8'h00;
      acc_q       <= 8'h01;
      step_q      <= '0;
      out_data_q  <= 8'h00;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      acc_q       <= acc_d;
      step_q      <= step_d;
      out_data_q  <= out_data_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Next-state logic; handshake flags are registered alongside the state
  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    acc_d       = acc_q;
    step_d      = step_q;
    out_data_d  = out_data_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          state_d    = ST_RUN;
          base_d     = in_data;
          acc_d      = 8'h01;
          step_d     = '0;
          in_ready_d = 1'b0;
        end
      end

      ST_RUN: begin
        if (INV_EXP[step_q]) begin
          acc_d = mul_c;
        end
        base_d = sq_c;
        if (step_q == STEP_W'(7)) begin
          // Last bit: hold step at 7 and publish the final accumulator
          state_d     = ST_DONE;
          out_data_d  = acc_d;
          out_valid_d = 1'b1;
        end else begin
          step_d = step_q + STEP_W'(1);
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_gal8_inv_seq.sv
// Directed and sweep bench for gal8_inv_seq.
module tb_gal8_inv_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gal8_inv_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Reference multiply: carry-less product, then polynomial long division
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
    return p[7:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full operation: accept, wait for result, optional stall, release
  task automatic run_op(input logic [7:0] a, input int stall, input bit noise,
                        output logic [7:0] res, output int lat);
    logic [7:0] held;
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_data  = a;
    tick();
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    check("in_ready_busy", 32'(in_ready), 32'd0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      if (noise) begin
        in_valid = 1'b1;
        in_data  = 8'h11;
      end
      tick();
      lat++;
      if (noise) check("noise_in_ready", 32'(in_ready), 32'd0);
    end
    if (!out_valid) begin
      check("timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      res = 8'h00;
      return;
    end
    res  = out_data;
    held = out_data;
    for (int i = 0; i < stall; i++) begin
      tick();
      check("stall_valid", 32'(out_valid), 32'd1);
      check("stall_data", 32'(out_data), 32'(held));
      check("stall_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready), 32'd1);
    check("release_valid", 32'(out_valid), 32'd0);
  endtask

  logic [7:0] ops  [5] = '{8'h53, 8'h01, 8'h02, 8'hCA, 8'h00};
  logic [7:0] exps [5] = '{8'hCA, 8'h01, 8'h8D, 8'h53, 8'h00};

  initial begin
    logic [7:0] res;
    int lat;

    rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;
    tick();
    tick();
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h00);
    rst = 1'b0;

    // out_ready in IDLE has no effect
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("idle_ready_in_ready", 32'(in_ready), 32'd1);
    check("idle_ready_valid", 32'(out_valid), 32'd0);

    // Directed operands
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], 0, 1'b0, res, lat);
      check($sformatf("inv_%02h", ops[i]), 32'(res), 32'(exps[i]));
      check("latency", 32'(lat), 32'd8);
    end

    // Backpressure for 20 cycles
    run_op(8'h53, 20, 1'b0, res, lat);
    check("bp_inv_53", 32'(res), 32'hCA);

    // in_valid during RUN is ignored
    run_op(8'h53, 2, 1'b1, res, lat);
    check("noise_inv_53", 32'(res), 32'hCA);
    check("noise_latency", 32'(lat), 32'd8);

    // Reset mid-RUN at step 4
    in_valid = 1'b1; in_data = 8'h53;
    tick();
    in_valid = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_out_data", 32'(out_data), 32'h00);
    repeat (10) tick();
    check("midrst_no_output", 32'(out_valid), 32'd0);
    run_op(8'h02, 0, 1'b0, res, lat);
    check("post_rst_inv_02", 32'(res), 32'h8D);

    // Reset in DONE beats out_ready
    in_valid = 1'b1; in_data = 8'h02;
    tick();
    in_valid = 1'b0;
    repeat (8) tick();
    check("done_valid", 32'(out_valid), 32'd1);
    check("done_data", 32'(out_data), 32'h8D);
    rst = 1'b1; out_ready = 1'b1;
    tick();
    rst = 1'b0; out_ready = 1'b0;
    check("donerst_in_ready", 32'(in_ready), 32'd1);
    check("donerst_out_valid", 32'(out_valid), 32'd0);
    check("donerst_out_data", 32'(out_data), 32'h00);

    // Exhaustive sweep with random stalls
    for (int a = 0; a < 256; a++) begin
      run_op(8'(a), int'($urandom_range(0, 3)), 1'b0, res, lat);
      if (a == 0) check("sweep_zero", 32'(res), 32'h00);
      else check($sformatf("sweep_%02h", a), 32'(gf_mul(8'(a), res)), 32'h01);
      check("sweep_latency", 32'(lat), 32'd8);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
